// File: rtl/mult_arb_pkg.sv
// ============================================================================
// Module      : mult_arb_pkg
// Description : Shared types and constants for the multiplier arbiter:
//               FSM state encoding, operand/result width, default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DATA_W      = 16;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 64;

  // Width needed to index n items (at least one bit so vectors stay legal)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Scans req starting at
//               rr_ptr and wrapping, returns the first set index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
  import mult_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   index
);

  // Candidate position carries one extra bit so ptr+k can exceed NREQ-1
  // before it is folded back into range.
  logic [IW:0] cand;

  // First requester at or after the pointer, searching cyclically
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter sharing one multiplier among NREQ
//               requesters. Each transaction runs IDLE -> ISSUE -> WAIT ->
//               RESP; the winner's operands are registered at grant time and
//               the product is returned with a one-hot ack pulse.
//               Optional feature macro: MULT_ARB_TIMEOUT_EN -- aborts WAIT
//               after TIMEOUT cycles, returning Result=0 with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] A_in,
  input  logic [DATA_W*NREQ-1:0] B_in,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      Result,
  output logic                   err,
  output logic                   busy,
  output logic                   mult_start,
  output logic [DATA_W-1:0]      mult_A,
  output logic [DATA_W-1:0]      mult_B,
  input  logic                   mult_done,
  input  logic [DATA_W-1:0]      mult_result
);

  localparam int IW = idx_width(NREQ);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_arbiter: TIMEOUT must be at least 1");
  end

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant;
  logic              pick_valid;
  logic [IW-1:0]     pick_index;
  logic              timeout_hit;

  logic [DATA_W-1:0] a_slice [NREQ];
  logic [DATA_W-1:0] b_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_slice[i] = A_in[i*DATA_W +: DATA_W];
    assign b_slice[i] = B_in[i*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_index)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT));
  assign err         = err_q;

  // WAIT-cycle counter (zeroed in ISSUE so each WAIT starts at 0) and the
  // abort flag, which is raised on timeout and lives through RESP only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !timeout_hit) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state == WAIT && !mult_done && timeout_hit) begin
        err_q <= 1'b1;
      end else if (state == RESP) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a real Done wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mult_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, operand registers, result capture and pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant  <= '0;
      rr_ptr <= '0;
      mult_A <= '0;
      mult_B <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant  <= pick_index;
            mult_A <= a_slice[pick_index];
            mult_B <= b_slice[pick_index];
          end
        end
        WAIT: begin
          if (mult_done) begin
            Result <= mult_result;
          end else if (timeout_hit) begin
            Result <= '0;
          end
        end
        RESP: begin
          rr_ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // One-hot completion pulse for the granted requester
  always_comb begin
    ack = '0;
    if (state == RESP) begin
      ack[grant] = 1'b1;
    end
  end

  assign mult_start = (state == ISSUE);
  assign busy       = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter: directed vector table,
//               contention/wrap/reset/timeout sequences, and randomized
//               traffic against a round-robin reference model.
//               Honours MULT_ARB_TIMEOUT_EN for the timeout sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [63:0]   A_in;
  logic [63:0]   B_in;
  logic [N-1:0]  ack;
  logic [15:0]   Result;
  logic          err;
  logic          busy;
  logic          mult_start;
  logic [15:0]   mult_A;
  logic [15:0]   mult_B;
  logic          mult_done;
  logic [15:0]   mult_result;

  int n_checks = 0;
  int n_fail   = 0;

  mult_arbiter #(
    .NREQ    (N),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .A_in        (A_in),
    .B_in        (B_in),
    .ack         (ack),
    .Result      (Result),
    .err         (err),
    .busy        (busy),
    .mult_start  (mult_start),
    .mult_A      (mult_A),
    .mult_B      (mult_B),
    .mult_done   (mult_done),
    .mult_result (mult_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- multiplier model ----------------
  int          mult_delay  = 1;
  bit          mult_hang   = 1'b0;
  bit          inject_done = 1'b0;
  int          m_cnt;
  bit          m_busy;
  logic [15:0] m_res;
  logic [31:0] m_prod;

  initial begin
    mult_done   = 1'b0;
    mult_result = 16'h0;
    m_busy      = 1'b0;
    m_cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      mult_done   = 1'b0;
      mult_result = 16'($urandom);
      if (rst) begin
        m_busy = 1'b0;
      end else if (mult_start) begin
        m_prod = 32'(mult_A) * 32'(mult_B);
        m_res  = m_prod[15:0];
        m_busy = 1'b1;
        m_cnt  = 0;
      end else if (m_busy && !mult_hang) begin
        m_cnt++;
        if (m_cnt >= mult_delay) begin
          mult_done   = 1'b1;
          mult_result = m_res;
          m_busy      = 1'b0;
        end
      end
      if (inject_done) begin
        mult_done   = 1'b1;
        mult_result = 16'hDEAD;
        inject_done = 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req       = '0;
    mult_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scramble_others(input logic [N-1:0] keep);
    req = req | (N'($urandom) & ~keep);
    for (int i = 0; i < N; i++) begin
      if (!keep[i]) begin
        A_in[i*16 +: 16] = 16'($urandom);
        B_in[i*16 +: 16] = 16'($urandom);
      end
    end
  endtask

  // Entered at a negedge where the DUT sits in IDLE; returns in the IDLE
  // cycle following the ack.
  task automatic do_txn(input logic [N-1:0] r, input logic [63:0] a, input logic [63:0] b,
                        input int dly, input logic [N-1:0] exp_ack,
                        input logic [15:0] exp_res, input bit scramble);
    int cyc;
    int starts;
    bit got;
    req        = r;
    A_in       = a;
    B_in       = b;
    mult_delay = dly;
    cyc        = 0;
    starts     = 0;
    got        = 1'b0;
    while (!got && cyc < dly + 20) begin
      @(negedge clk);
      cyc++;
      if (mult_start) starts++;
      if (cyc == 1) check("start_cycle", 32'(mult_start), 32'd1);
      if (scramble && cyc == 2) scramble_others(exp_ack);
      if (ack != '0) begin
        got = 1'b1;
        check("ack_vec", 32'(ack), 32'(exp_ack));
        check("result", 32'(Result), 32'(exp_res));
        check("err_on_ack", 32'(err), 32'd0);
        check("ack_latency", 32'(cyc), 32'(dly + 2));
        check("start_count", 32'(starts), 32'd1);
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("idle_after", {29'd0, busy, mult_start, |ack}, 32'd0);
    check("result_hold", 32'(Result), 32'(exp_res));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic [63:0]  a;
    logic [63:0]  b;
    int           dly;
    logic [N-1:0] ack;
    logic [15:0]  res;
  } vec_t;

  vec_t tbl [8];

  // round-robin reference state for the random phase
  int m_ptr;

  initial begin
    logic [15:0] cres [4];
    logic [63:0] a;
    logic [63:0] b;
    logic [N-1:0] r;
    logic [31:0] p;
    int w;

    // Directed vectors from reset (pointer starts at 0)
    tbl[0] = '{4'b0001, {16'd5, 16'd6, 16'd7, 16'd100},   {16'd9, 16'd9, 16'd9, 16'd200},   3, 4'b0001, 16'd20000};
    tbl[1] = '{4'b1001, {16'd7, 16'd1, 16'd1, 16'd1},     {16'd9, 16'd2, 16'd2, 16'd2},     1, 4'b1000, 16'd63};
    tbl[2] = '{4'b1001, {16'd4, 16'd4, 16'd4, 16'd300},   {16'd4, 16'd4, 16'd4, 16'd300},   2, 4'b0001, 16'd24464};
    tbl[3] = '{4'b1001, {16'd2, 16'd11, 16'd11, 16'd11},  {16'd3, 16'd11, 16'd11, 16'd11},  5, 4'b1000, 16'd6};
    tbl[4] = '{4'b0110, {16'd3, 16'd3, 16'hFFFF, 16'd3},  {16'd3, 16'd3, 16'hFFFF, 16'd3},  1, 4'b0010, 16'd1};
    tbl[5] = '{4'b0110, {16'd5, 16'd1000, 16'd5, 16'd5},  {16'd5, 16'd0, 16'd5, 16'd5},     4, 4'b0100, 16'd0};
    tbl[6] = '{4'b0010, {16'd1, 16'd1, 16'd255, 16'd1},   {16'd1, 16'd1, 16'd255, 16'd1},   2, 4'b0010, 16'd65025};
    tbl[7] = '{4'b0001, {16'd9, 16'd9, 16'd9, 16'd12345}, {16'd9, 16'd9, 16'd9, 16'd1},     6, 4'b0001, 16'd12345};

    rst  = 1'b1;
    req  = '0;
    A_in = '0;
    B_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy_start_err", {29'd0, busy, mult_start, err}, 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_operands", {mult_A, mult_B}, 32'd0);
    rst = 1'b0;

    // idle with no requests
    repeat (3) begin
      @(negedge clk);
      check("idle_quiet", {29'd0, busy, mult_start, |ack}, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].ack, tbl[i].res, 1'b0);
    end

    // Contention: all four requesting, 10-cycle multiplier
    do_reset();
    cres = '{16'd20, 16'd60, 16'd120, 16'd200};
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, {16'd5, 16'd4, 16'd3, 16'd2}, {16'd40, 16'd30, 16'd20, 16'd10},
             10, N'(1) << (k % 4), cres[k % 4], 1'b0);
    end
    // pointer now 1: grant to 2 moves it to 3
    do_txn(4'b0100, {16'd1, 16'd7, 16'd1, 16'd1}, {16'd1, 16'd7, 16'd1, 16'd1}, 2, 4'b0100, 16'd49, 1'b0);

    // Reset in the middle of WAIT
    req       = 4'b1000;
    A_in      = {16'd3, 16'd0, 16'd0, 16'd0};
    B_in      = {16'd5, 16'd0, 16'd0, 16'd0};
    mult_hang = 1'b1;
    @(negedge clk);
    check("mid_start", 32'(mult_start), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("mid_no_ack", 32'(ack), 32'd0);
    end
    rst = 1'b1;
    req = '0;
    #1;
    check("async_rst_busy", {30'd0, busy, mult_start}, 32'd0);
    check("async_rst_result", 32'(Result), 32'd0);
    @(negedge clk);
    check("rst_operands2", {mult_A, mult_B}, 32'd0);
    check("rst_ptr", 32'(dut.rr_ptr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst       = 1'b0;
    mult_hang = 1'b0;
    inject_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_quiet", {29'd0, busy, mult_start, |ack}, 32'd0);
    end
    check("spurious_done_ignored", 32'(Result), 32'd0);
    do_txn(4'b0100, {16'd0, 16'd12, 16'd0, 16'd0}, {16'd0, 16'd12, 16'd0, 16'd0}, 3, 4'b0100, 16'd144, 1'b0);

    // First grant after reset goes to the lowest active index
    do_reset();
    do_txn(4'b1010, {16'd2, 16'd0, 16'd21, 16'd0}, {16'd2, 16'd0, 16'd2, 16'd0}, 2, 4'b0010, 16'd42, 1'b0);

    // Multiplier never answers
    do_reset();
    req       = 4'b0001;
    A_in      = {48'd0, 16'd77};
    B_in      = {48'd0, 16'd3};
    mult_hang = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
    begin
      int cyc;
      bit got;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 120) begin
        @(negedge clk);
        cyc++;
        if (ack != '0) begin
          got = 1'b1;
          check("to_latency", 32'(cyc), 32'd67);
          check("to_ack", 32'(ack), 32'b0001);
          check("to_err", 32'(err), 32'd1);
          check("to_result", 32'(Result), 32'd0);
        end else begin
          check("to_err_quiet", 32'(err), 32'd0);
        end
      end
      check("to_ack_seen", 32'(got), 32'd1);
      req = '0;
      @(negedge clk);
      check("to_err_clear", 32'(err), 32'd0);
    end
`else
    begin
      int acks;
      acks = 0;
      repeat (202) begin
        @(negedge clk);
        if (ack != '0) acks++;
      end
      check("hang_no_ack", 32'(acks), 32'd0);
      check("hang_busy", 32'(busy), 32'd1);
      check("hang_err", 32'(err), 32'd0);
    end
`endif

    // Randomized traffic against the round-robin model
    do_reset();
    m_ptr = 0;
    for (int it = 0; it < 60; it++) begin
      r = N'($urandom_range(0, 15));
      if (r == '0) begin
        req = '0;
        repeat (3) begin
          @(negedge clk);
          check("rand_idle", {29'd0, busy, mult_start, |ack}, 32'd0);
        end
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        p = 32'(a[w*16 +: 16]) * 32'(b[w*16 +: 16]);
        do_txn(r, a, b, $urandom_range(1, 8), N'(1) << w, p[15:0], 1'b1);
        m_ptr = (w + 1) % N;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
